mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOUT, register file, ALU and
// operand / next-PC muxes. All sequencing comes from an external controller.
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucont,
    input  logic [31:0] readdata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero,
    output logic [31:0] adr,
    output logic [31:0] writedata
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NADDR = 2 ** AW;

    logic [XLEN-1:0] pc, ir, mdr, a, b, aluout;
    logic [NADDR-1:0][XLEN-1:0] rf;
    logic [AW-1:0]   ra1, ra2, wa;
    logic [XLEN-1:0] rd1, rd2, wd;
    logic [XLEN-1:0] signimm, srca, srcb, aluresult, pcnext;

    assign ra1 = ir[25:21];
    assign ra2 = ir[20:16];
    assign wa  = regdst ? ir[15:11] : ir[20:16];
    assign wd  = memtoreg ? mdr : aluout;

    // Entry 0 and any index beyond NREGS are hardwired to zero
    for (genvar i = 0; i < int'(NADDR); i++) begin : g_rf
        if (i == 0 || i >= int'(NREGS)) begin : g_zero
            assign rf[i] = '0;
        end else begin : g_reg
            logic [XLEN-1:0] q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (regwrite && wa == AW'(i)) begin
                    q <= wd;
                end
            end
            assign rf[i] = q;
        end
    end

    // Reads see the pre-edge contents; no write bypass
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    assign signimm = {{16{ir[15]}}, ir[15:0]};
    assign srca    = alusrca ? a : pc;

    always_comb begin
        srcb = b;
        case (alusrcb)
            2'b00:   srcb = b;
            2'b01:   srcb = XLEN'(4);
            2'b10:   srcb = signimm;
            default: srcb = {signimm[XLEN-3:0], 2'b00};
        endcase
    end

    always_comb begin
        aluresult = '0;
        case (alucont)
            3'b010:  aluresult = srca + srcb;
            3'b110:  aluresult = srca - srcb;
            3'b000:  aluresult = srca & srcb;
            3'b001:  aluresult = srca | srcb;
            3'b111:  aluresult = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
            default: aluresult = '0;
        endcase
    end

    always_comb begin
        pcnext = pc;
        case (pcsrc)
            2'b00:   pcnext = aluresult;
            2'b01:   pcnext = aluout;
            2'b10:   pcnext = {pc[31:28], ir[25:0], 2'b00};
            default: pcnext = pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (pcen) begin
                pc <= pcnext;
            end
            if (irwrite) begin
                ir <= readdata;
            end
            mdr    <= readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign zero      = (aluresult == '0);
    assign adr       = iord ? aluout : pc;
    assign writedata = b;

endmodule
